// File: rtl/speck_core_arbiter_pkg.sv
// Shared types for the SPECK core arbiter: cipher width and the job FSM encoding.
package speck_core_arbiter_pkg;

    localparam int unsigned KEY_SIZE = 128;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStart = 3'd2,
        StWait  = 3'd3,
        StResp  = 3'd4
    } state_e;

endpackage

// File: rtl/speck_core_arbiter_if.sv
// Client-side request/response bundle; master = requesters, slave = arbiter.
interface speck_core_arbiter_if
    import speck_core_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W  = KEY_SIZE,
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_mode;
    logic [NUM_REQ*DATA_W-1:0] req_text;
    logic [NUM_REQ*DATA_W-1:0] req_key;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_err;

    modport master (
        output req, req_mode, req_text, req_key,
        input  grant, ack, resp_data, resp_err
    );

    modport slave (
        input  req, req_mode, req_text, req_key,
        output grant, ack, resp_data, resp_err
    );
endinterface

// File: rtl/speck_core_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module speck_core_arbiter_rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        // Offset k walks outward from ptr; j is the candidate that offset lands on.
        for (int k = 0; k < int'(N); k++) begin
            for (int j = 0; j < int'(N); j++) begin
                if (!valid && req[j] && (((32'(ptr) + 32'(k)) % N) == 32'(j))) begin
                    valid     = 1'b1;
                    winner[j] = 1'b1;
                    idx       = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/speck_core_arbiter.sv
// Shares one SPECK encrypt/decrypt core pair between NUM_REQ round-robin requesters.
module speck_core_arbiter
    import speck_core_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W  = KEY_SIZE,
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned TO_W    = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    speck_core_arbiter_if.slave bus,
    output logic              core_start_enc,
    output logic              core_start_dec,
    output logic [DATA_W-1:0] core_text,
    output logic [DATA_W-1:0] core_key,
    input  logic [DATA_W-1:0] core_result_enc,
    input  logic [DATA_W-1:0] core_result_dec,
    input  logic              core_ready_enc,
    input  logic              core_ready_dec
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [IW-1:0]      sel_q, sel_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic               mode_q, mode_d;
    logic [DATA_W-1:0]  text_q, text_d;
    logic [DATA_W-1:0]  key_q, key_d;
    logic [TO_W-1:0]    wd_q, wd_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic               resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0] eligible, pick_oh, sel_oh, grant_c, ack_c;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid, ready_sel, wd_expire;

    assign eligible  = bus.req & ~mask_q;
    // Only the core that was started may complete the job.
    assign ready_sel = mode_q ? core_ready_dec : core_ready_enc;
    assign wd_expire = (wd_q == TO_W'(TIMEOUT - 2));

    speck_core_arbiter_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req    (eligible),
        .ptr    (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_oh),
        .idx    (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            sel_oh[i] = (sel_q == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_valid) state_d = StLoad;
            StLoad:  state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (ready_sel || wd_expire) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_c        = '0;
        ack_c          = '0;
        core_start_enc = 1'b0;
        core_start_dec = 1'b0;
        unique case (state_q)
            StIdle: ;
            StLoad, StWait: grant_c = sel_oh;
            StStart: begin
                grant_c        = sel_oh;
                core_start_enc = ~mode_q;
                core_start_dec = mode_q;
            end
            StResp: begin
                grant_c = sel_oh;
                ack_c   = sel_oh;
            end
            default: ;
        endcase
    end

    always_comb begin
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        text_d      = text_q;
        key_d       = key_q;
        wd_d        = wd_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        unique case (state_q)
            StIdle: begin
                mask_d = '0;
                if (pick_valid) sel_d = pick_idx;
            end
            StLoad: begin
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    if (sel_q == IW'(i)) begin
                        text_d = bus.req_text[i*DATA_W +: DATA_W];
                        key_d  = bus.req_key[i*DATA_W +: DATA_W];
                        mode_d = bus.req_mode[i];
                    end
                end
                rr_ptr_d = (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
            end
            StStart: wd_d = '0;
            StWait: begin
                // Ready takes priority over an expiry landing in the same cycle.
                if (ready_sel) begin
                    resp_data_d = mode_q ? core_result_dec : core_result_enc;
                    resp_err_d  = 1'b0;
                end else if (wd_expire) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StResp: begin
                mask_d      = sel_oh;
                resp_data_d = '0;
                resp_err_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            mask_q      <= '0;
            mode_q      <= 1'b0;
            text_q      <= '0;
            key_q       <= '0;
            wd_q        <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            text_q      <= text_d;
            key_q       <= key_d;
            wd_q        <= wd_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign bus.grant     = grant_c;
    assign bus.ack       = ack_c;
    assign bus.resp_data = resp_data_q;
    assign bus.resp_err  = resp_err_q;
    assign core_text     = text_q;
    assign core_key      = key_q;

endmodule

// File: tb/tb_speck_core_arbiter.sv
// Directed bench: u_a (TIMEOUT 64) for job flow, u_b (TIMEOUT 16) for watchdog cases.
module tb_speck_core_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks, errors, n;

    always #5 clk = ~clk;

    speck_core_arbiter_if #(.DATA_W(128), .NUM_REQ(2)) bus_a ();
    speck_core_arbiter_if #(.DATA_W(128), .NUM_REQ(2)) bus_b ();

    logic         a_start_enc, a_start_dec, a_rdy_enc, a_rdy_dec;
    logic [127:0] a_text, a_key, a_res_enc, a_res_dec;
    logic         b_start_enc, b_start_dec, b_rdy_enc, b_rdy_dec;
    logic [127:0] b_text, b_key, b_res_enc, b_res_dec;

    speck_core_arbiter #(.DATA_W(128), .NUM_REQ(2), .TIMEOUT(64), .TO_W(7)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
        .core_start_enc(a_start_enc), .core_start_dec(a_start_dec),
        .core_text(a_text), .core_key(a_key),
        .core_result_enc(a_res_enc), .core_result_dec(a_res_dec),
        .core_ready_enc(a_rdy_enc), .core_ready_dec(a_rdy_dec)
    );

    speck_core_arbiter #(.DATA_W(128), .NUM_REQ(2), .TIMEOUT(16), .TO_W(5)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
        .core_start_enc(b_start_enc), .core_start_dec(b_start_dec),
        .core_text(b_text), .core_key(b_key),
        .core_result_enc(b_res_enc), .core_result_dec(b_res_dec),
        .core_ready_enc(b_rdy_enc), .core_ready_dec(b_rdy_dec)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_a.req = '0; bus_a.req_mode = '0; bus_a.req_text = '0; bus_a.req_key = '0;
        bus_b.req = '0; bus_b.req_mode = '0; bus_b.req_text = '0; bus_b.req_key = '0;
        a_rdy_enc = 1'b0; a_rdy_dec = 1'b0; a_res_enc = '0; a_res_dec = '0;
        b_rdy_enc = 1'b0; b_rdy_dec = 1'b0; b_res_enc = '0; b_res_dec = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        do_reset();
        check("rst_grant", 128'(bus_a.grant), 128'h0);
        check("rst_ack", 128'(bus_a.ack), 128'h0);
        check("rst_resp", 128'({bus_a.resp_err, bus_a.resp_data[7:0]}), 128'h0);
        check("rst_start", 128'({a_start_enc, a_start_dec}), 128'h0);
        check("rst_core_in", 128'({a_text[7:0], a_key[7:0]}), 128'h0);

        // Single encrypt, core answers 40 cycles after start.
        bus_a.req = 2'b01;
        step();
        check("t1_load_grant", 128'(bus_a.grant), 128'h1);
        check("t1_load_start", 128'({a_start_enc, a_start_dec}), 128'h0);
        step();
        check("t1_start", 128'({a_start_enc, a_start_dec}), 128'h2);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_a.ack != 2'b00 || a_start_enc || a_start_dec || bus_a.grant != 2'b01) n++;
        end
        check("t1_wait_quiet", 128'(n), 128'h0);
        a_rdy_enc = 1'b1;
        a_res_enc = 128'h1e9ed4a7_00000000_5c1b7ea0_12345678;
        step();
        a_rdy_enc = 1'b0;
        check("t1_ack", 128'(bus_a.ack), 128'h1);
        check("t1_data", bus_a.resp_data, 128'h1e9ed4a7_00000000_5c1b7ea0_12345678);
        check("t1_err", 128'(bus_a.resp_err), 128'h0);
        bus_a.req = 2'b00;
        step();
        check("t1_idle_ack", 128'(bus_a.ack), 128'h0);
        check("t1_idle_data", bus_a.resp_data, 128'h0);
        check("t1_idle_grant", 128'(bus_a.grant), 128'h0);

        // Contention: both requesters held, order must alternate 0,1,0,1.
        do_reset();
        bus_a.req      = 2'b11;
        bus_a.req_text = {128'hbbbb, 128'haaaa};
        bus_a.req_key  = {128'h2222, 128'h1111};
        for (int j = 0; j < 4; j++) begin
            step();
            check($sformatf("t2_grant%0d", j), 128'(bus_a.grant), (j % 2 == 0) ? 128'h1 : 128'h2);
            step();
            check($sformatf("t2_text%0d", j), a_text, (j % 2 == 0) ? 128'haaaa : 128'hbbbb);
            check($sformatf("t2_key%0d", j), a_key, (j % 2 == 0) ? 128'h1111 : 128'h2222);
            step();
            a_rdy_enc = 1'b1;
            a_res_enc = 128'h500 + 128'(j);
            step();
            a_rdy_enc = 1'b0;
            check($sformatf("t2_ack%0d", j), 128'(bus_a.ack), (j % 2 == 0) ? 128'h1 : 128'h2);
            check($sformatf("t2_data%0d", j), bus_a.resp_data, 128'h500 + 128'(j));
            if (j == 3) bus_a.req = 2'b00;
            step();
        end
        check("t2_final_grant", 128'(bus_a.grant), 128'h0);

        // Decrypt routing; stale dec ready in START and spurious enc ready in WAIT ignored.
        do_reset();
        bus_a.req      = 2'b10;
        bus_a.req_mode = 2'b10;
        bus_a.req_text = {128'hc0c0, 128'h0};
        bus_a.req_key  = {128'hd0d0, 128'h0};
        step();
        check("t3_grant", 128'(bus_a.grant), 128'h2);
        step();
        check("t3_start", 128'({a_start_enc, a_start_dec}), 128'h1);
        check("t3_text", a_text, 128'hc0c0);
        check("t3_key", a_key, 128'hd0d0);
        a_rdy_dec = 1'b1;
        a_res_dec = 128'hdead;
        step();
        a_rdy_dec = 1'b0;
        check("t3_stale_ready", 128'(bus_a.ack), 128'h0);
        a_rdy_enc = 1'b1;
        a_res_enc = 128'he0e0;
        step();
        a_rdy_enc = 1'b0;
        check("t3_spurious_enc", 128'(bus_a.ack), 128'h0);
        check("t3_wait_grant", 128'(bus_a.grant), 128'h2);
        a_rdy_dec = 1'b1;
        a_res_dec = 128'hf0f0;
        step();
        a_rdy_dec = 1'b0;
        check("t3_ack", 128'(bus_a.ack), 128'h2);
        check("t3_data", bus_a.resp_data, 128'hf0f0);
        bus_a.req = 2'b00;
        step();

        // Reset in the middle of WAIT abandons the job silently.
        do_reset();
        bus_a.req      = 2'b01;
        bus_a.req_text = {128'h0, 128'h4b4b};
        bus_a.req_key  = {128'h0, 128'h4c4c};
        step();
        step();
        step();
        step();
        rst_n     = 1'b0;
        bus_a.req = 2'b00;
        step();
        check("t5_grant", 128'(bus_a.grant), 128'h0);
        check("t5_ack", 128'(bus_a.ack), 128'h0);
        check("t5_core_in", 128'({a_text[15:0], a_key[15:0]}), 128'h0);
        check("t5_start", 128'({a_start_enc, a_start_dec}), 128'h0);
        rst_n     = 1'b1;
        a_rdy_enc = 1'b1;
        a_res_enc = 128'h3333;
        step();
        a_rdy_enc = 1'b0;
        check("t5_stale_ack", 128'(bus_a.ack), 128'h0);
        check("t5_stale_data", bus_a.resp_data, 128'h0);
        bus_a.req      = 2'b10;
        bus_a.req_text = {128'h6e6e, 128'h0};
        step();
        check("t5_grant_new", 128'(bus_a.grant), 128'h2);
        step();
        check("t5_start_new", 128'({a_start_enc, a_start_dec}), 128'h2);
        check("t5_text_new", a_text, 128'h6e6e);
        step();
        a_rdy_enc = 1'b1;
        a_res_enc = 128'h7070;
        step();
        a_rdy_enc = 1'b0;
        check("t5_ack_new", 128'(bus_a.ack), 128'h2);
        check("t5_data_new", bus_a.resp_data, 128'h7070);
        bus_a.req = 2'b00;
        step();

        // Timeout on u_b: ack with error exactly 16 cycles after START.
        do_reset();
        b_res_enc = 128'h9999;
        bus_b.req = 2'b01;
        step();
        step();
        check("t4_start", 128'({b_start_enc, b_start_dec}), 128'h2);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus_b.ack != 2'b00) n++;
        end
        check("t4_early_ack", 128'(n), 128'h0);
        step();
        check("t4_ack", 128'(bus_b.ack), 128'h1);
        check("t4_err", 128'(bus_b.resp_err), 128'h1);
        check("t4_data", bus_b.resp_data, 128'h0);
        bus_b.req = 2'b00;
        step();
        check("t4_err_clear", 128'(bus_b.resp_err), 128'h0);
        bus_b.req      = 2'b10;
        bus_b.req_mode = 2'b10;
        step();
        check("t4_next_grant", 128'(bus_b.grant), 128'h2);
        step();
        check("t4_next_start", 128'({b_start_enc, b_start_dec}), 128'h1);
        step();
        b_rdy_dec = 1'b1;
        b_res_dec = 128'h4848;
        step();
        b_rdy_dec = 1'b0;
        check("t4_next_ack", 128'(bus_b.ack), 128'h2);
        check("t4_next_err", 128'(bus_b.resp_err), 128'h0);
        check("t4_next_data", bus_b.resp_data, 128'h4848);
        bus_b.req      = 2'b00;
        bus_b.req_mode = 2'b00;
        step();

        // Ready on the last watchdog count wins over expiry.
        bus_b.req = 2'b01;
        step();
        step();
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus_b.ack != 2'b00) n++;
        end
        check("t6_early_ack", 128'(n), 128'h0);
        b_rdy_enc = 1'b1;
        b_res_enc = 128'habcd;
        step();
        b_rdy_enc = 1'b0;
        check("t6_ack", 128'(bus_b.ack), 128'h1);
        check("t6_err", 128'(bus_b.resp_err), 128'h0);
        check("t6_data", bus_b.resp_data, 128'habcd);
        bus_b.req = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
